// File: rtl/dinorun_pkg.sv
// Shared display constants for the dinorun score path: segment patterns,
// blank pattern and digit count.
package dinorun_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,   // F
        7'b0000110,   // E
        7'b0100001,   // d
        7'b1000110,   // C
        7'b0000011,   // b
        7'b0001000,   // A
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    typedef struct packed {
        logic       en;
        logic [3:0] val;
    } digit_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        return SEG_TABLE[v];
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7seg
    import dinorun_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] segments
);

    assign segments = seg_decode(value);

endmodule

// File: rtl/score_display_scanner.sv
// Four-digit multiplexed seven-segment scanner with per-frame snapshot and
// dead-time blanking. Optional leading-zero blanking via LEADING_ZERO_BLANK_EN.
module score_display_scanner
    import dinorun_pkg::*;
#(
    parameter int PRESCALE = 65536,
    parameter int DEADTIME = 256
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       digit0_en_i,
    input  logic       digit1_en_i,
    input  logic       digit2_en_i,
    input  logic       digit3_en_i,
    input  logic [3:0] digit0_i,
    input  logic [3:0] digit1_i,
    input  logic [3:0] digit2_i,
    input  logic [3:0] digit3_i,
    output logic [3:0] anode_o,
    output logic [6:0] segments_o,
    output logic       dp_o,
    output logic       frame_o
);

    localparam int              CNT_W    = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEADTIME);

    logic [CNT_W-1:0]      cnt_q;
    logic [1:0]            slot_q;
    digit_t                snap_q   [NUM_DIGITS];
    digit_t                in_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] visible;
    logic [6:0]            cur_seg;
    logic                  wrap;
    logic                  capture;
    logic                  lit;

    always_comb begin
        in_digit[0] = '{en: digit0_en_i, val: digit0_i};
        in_digit[1] = '{en: digit1_en_i, val: digit1_i};
        in_digit[2] = '{en: digit2_en_i, val: digit2_i};
        in_digit[3] = '{en: digit3_en_i, val: digit3_i};
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic upper_nz;

    // Walk from the most significant digit down; a zero stays dark until
    // some enabled non-zero digit has been seen above it.
    always_comb begin
        upper_nz = 1'b0;
        visible  = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            visible[k] = snap_q[k].en &&
                         ((k == 0) || (snap_q[k].val != 4'h0) || upper_nz);
            upper_nz   = upper_nz || (snap_q[k].en && (snap_q[k].val != 4'h0));
        end
    end
`else
    always_comb begin
        visible = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            visible[k] = snap_q[k].en;
        end
    end
`endif

    hex7seg u_hex7seg (
        .value    (snap_q[slot_q].val),
        .segments (cur_seg)
    );

    assign wrap    = (cnt_q == CNT_MAX);
    assign capture = wrap && (slot_q == 2'd3);
    assign lit     = (cnt_q >= CNT_DEAD) && visible[slot_q];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            slot_q     <= 2'd0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                snap_q[k] <= '0;
            end
            anode_o    <= 4'hF;
            segments_o <= SEG_BLANK;
            dp_o       <= 1'b1;
            frame_o    <= 1'b0;
        end else begin
            cnt_q <= wrap ? '0 : cnt_q + 1'b1;
            if (wrap) begin
                slot_q <= slot_q + 2'd1;
            end
            if (capture) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    snap_q[k] <= in_digit[k];
                end
            end
            frame_o    <= capture;
            anode_o    <= lit ? ~(4'b0001 << slot_q) : 4'hF;
            segments_o <= lit ? cur_seg : SEG_BLANK;
            dp_o       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_score_display_scanner.sv
// Scoreboard bench for score_display_scanner: a frame-arithmetic model
// predicts every output cycle, a monitor compares on the falling edge.
module tb_score_display_scanner;

    localparam int PS = 8;
    localparam int DT = 2;
    localparam int FRAME = 4 * PS;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] dv [4];
    logic       den [4];
    logic [3:0] anode;
    logic [6:0] segments;
    logic       dp;
    logic       frame;

    int checks = 0;
    int fails  = 0;

    exp_t exp_q [$];

    logic [6:0] ref_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    always #5 clk = ~clk;

    score_display_scanner #(.PRESCALE(PS), .DEADTIME(DT)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .digit0_en_i (den[0]),
        .digit1_en_i (den[1]),
        .digit2_en_i (den[2]),
        .digit3_en_i (den[3]),
        .digit0_i    (dv[0]),
        .digit1_i    (dv[1]),
        .digit2_i    (dv[2]),
        .digit3_i    (dv[3]),
        .anode_o     (anode),
        .segments_o  (segments),
        .dp_o        (dp),
        .frame_o     (frame)
    );

    // Reference model: time since reset alone decides slot and phase.
    int         n_edges = 0;
    logic [3:0] m_val [4];
    logic       m_en  [4];

    function automatic logic shown(input int k);
        logic above;
        above = 1'b0;
        for (int j = k + 1; j < 4; j++) begin
            if (m_en[j] && m_val[j] != 4'h0) above = 1'b1;
        end
        if (!m_en[k]) return 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        return (k == 0) || (m_val[k] != 4'h0) || above;
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clk) begin
        exp_t e;
        int   c;
        int   s;
        if (!rst_n) begin
            e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fr: 1'b0};
            n_edges = 0;
            for (int k = 0; k < 4; k++) begin
                m_val[k] = 4'h0;
                m_en[k]  = 1'b0;
            end
        end else begin
            c = n_edges % PS;
            s = (n_edges / PS) % 4;
            e.dp = 1'b1;
            e.fr = ((n_edges % FRAME) == FRAME - 1);
            if (c >= DT && shown(s)) begin
                e.an  = 4'hF & ~(4'(1) << s);
                e.seg = ref_tbl[m_val[s]];
            end else begin
                e.an  = 4'hF;
                e.seg = 7'h7F;
            end
            if (e.fr) begin
                for (int k = 0; k < 4; k++) begin
                    m_val[k] = dv[k];
                    m_en[k]  = den[k];
                end
            end
            n_edges++;
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (anode !== e.an || segments !== e.seg || dp !== e.dp || frame !== e.fr) begin
                fails++;
                $display("FAIL scan t=%0t: got an=%b seg=%b dp=%b fr=%b, want an=%b seg=%b dp=%b fr=%b",
                         $time, anode, segments, dp, frame, e.an, e.seg, e.dp, e.fr);
            end
        end
    end

    task automatic set_digits(input logic [3:0] v3, v2, v1, v0, input logic [3:0] en);
        dv[3] = v3; dv[2] = v2; dv[1] = v1; dv[0] = v0;
        for (int k = 0; k < 4; k++) den[k] = en[k];
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < FRAME + 8; i++) begin
            @(negedge clk);
            if (frame === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            fails++;
            $display("FAIL frame_wait: got no frame pulse within %0d cycles, want one", FRAME + 8);
        end
    endtask

    initial begin
        set_digits(4'h4, 4'h3, 4'h2, 4'h1, 4'b1111);
        @(negedge clk);
        rst_n = 1'b1;

        wait_frame();
        cycles(FRAME);

        set_digits(4'h4, 4'h3, 4'h2, 4'h5, 4'b1111);
        wait_frame();
        cycles(10);
        dv[0] = 4'h9;
        wait_frame();
        cycles(FRAME + 2);

        set_digits(4'h4, 4'h3, 4'h2, 4'h1, 4'b1011);
        wait_frame();
        cycles(FRAME + 2);

        set_digits(4'h0, 4'h0, 4'h0, 4'hA, 4'b1111);
        wait_frame();
        dv[0] = 4'h8;
        wait_frame();
        cycles(FRAME + 2);

        set_digits(4'h0, 4'h0, 4'h0, 4'h5, 4'b1111);
        wait_frame();
        cycles(FRAME + 2);

        set_digits(4'h0, 4'h7, 4'h0, 4'h0, 4'b1101);
        wait_frame();
        cycles(FRAME + 2);

        for (int f = 0; f < 24; f++) begin
            for (int c = 0; c < FRAME; c++) begin
                if ($urandom_range(0, 5) == 0) begin
                    int k;
                    k = $urandom_range(0, 3);
                    dv[k]  = 4'($urandom_range(0, 15));
                    den[k] = ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 2) == 0) dv[k] = 4'h0;
                end
                if (f == 12 && c == 13) rst_n = 1'b0;
                else rst_n = 1'b1;
                @(negedge clk);
            end
        end
        rst_n = 1'b1;
        cycles(3);

        checks++;
        if (exp_q.size() > 1) begin
            fails++;
            $display("FAIL drain: got %0d pending entries, want at most 1", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
